// File: rtl/cpu_rtype_pkg.sv
// Shared definitions for the single-cycle MIPS R-type datapath:
// opcode/funct codes, ALU operation encoding and the ALU control decode.
package cpu_rtype_pkg;

  localparam logic [5:0] R_TYPE      = 6'h00;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_NOR  = 3'd5,
    ALU_SLT  = 3'd6
  } alu_op_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_instr_t;

  // ALU_NONE marks every instruction that must execute as a NOP
  function automatic alu_op_t alu_control(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_t op;
    op = ALU_NONE;
    if (opcode == R_TYPE) begin
      case (funct)
        FUNCT_ADD: op = ALU_ADD;
        FUNCT_SUB: op = ALU_SUB;
        FUNCT_AND: op = ALU_AND;
        FUNCT_OR:  op = ALU_OR;
        FUNCT_NOR: op = ALU_NOR;
        FUNCT_SLT: op = ALU_SLT;
        default:   op = ALU_NONE;
      endcase
    end else begin
      op = ALU_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_rtype.sv
// 32-bit R-type ALU: modulo add/sub, bitwise and/or/nor, signed set-less-than.
module alu_rtype
  import cpu_rtype_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  // Operation select; unknown operations yield zero
  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: y = 32'd0;
    endcase
  end

endmodule

// File: rtl/cpu_rtype_br.sv
// Register bank: two combinational read ports, one write port on the rising edge.
module cpu_rtype_br #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] registerBank [0:DEPTH-1];

  // Write port; reset only blocks writes, stored values survive it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (we && (wa != 5'd0)) begin
      registerBank[wa] <= wd;
    end
  end

  // Read ports; register 0 is hard-wired to zero
  always_comb begin
    if (ra1 == 5'd0) rd1 = 32'd0;
    else             rd1 = registerBank[ra1];
    if (ra2 == 5'd0) rd2 = 32'd0;
    else             rd2 = registerBank[ra2];
  end

endmodule

// File: rtl/cpu_rtype_im.sv
// Instruction memory: word array read combinationally, contents loaded externally.
module cpu_rtype_im #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);

  logic [31:0] instBank [0:DEPTH-1] = '{default: 32'd0};

  assign instr = instBank[addr];

endmodule

// File: rtl/cpu_control_rtype.sv
// Single-cycle MIPS R-type datapath: PC, instruction memory (IM), register
// bank (BR), ALU control and ALU. resultado is the current instruction's result.
module cpu_control_rtype
  import cpu_rtype_pkg::*;
#(
  parameter int IM_DEPTH = 64,
  parameter int RF_DEPTH = 32
) (
  input  logic        clk_CPU,
  input  logic        rst_n,
  output logic [31:0] resultado
);

  localparam int          IM_AW   = $clog2(IM_DEPTH);
  localparam logic [31:0] PC_LAST = 32'(4 * (IM_DEPTH - 1));

  logic [31:0]  pc_r = 32'd0;
  logic [31:0]  pc_next_s;
  logic [31:0]  instr_word_s;
  rtype_instr_t instr_s;
  alu_op_t      op_s;
  logic [31:0]  rd1_s;
  logic [31:0]  rd2_s;
  logic [31:0]  alu_y_s;
  logic         we_s;
  logic         unused_s;

  // Next PC: one word ahead, wrapping to 0 after the last IM entry
  always_comb begin
    if (pc_r == PC_LAST) pc_next_s = 32'd0;
    else                 pc_next_s = pc_r + 32'd4;
  end

  // Program counter
  always_ff @(posedge clk_CPU or negedge rst_n) begin
    if (!rst_n) pc_r <= 32'd0;
    else        pc_r <= pc_next_s;
  end

  cpu_rtype_im #(.DEPTH(IM_DEPTH), .AW(IM_AW)) IM (
    .addr  (pc_r[IM_AW+1:2]),
    .instr (instr_word_s)
  );

  assign instr_s = rtype_instr_t'(instr_word_s);
  assign op_s    = alu_control(instr_s.opcode, instr_s.funct);

  cpu_rtype_br #(.DEPTH(RF_DEPTH)) BR (
    .clk   (clk_CPU),
    .rst_n (rst_n),
    .we    (we_s),
    .wa    (instr_s.rd),
    .wd    (resultado),
    .ra1   (instr_s.rs),
    .ra2   (instr_s.rt),
    .rd1   (rd1_s),
    .rd2   (rd2_s)
  );

  alu_rtype ALU (
    .a  (rd1_s),
    .b  (rd2_s),
    .op (op_s),
    .y  (alu_y_s)
  );

  // Result and write enable; unsupported instructions are NOPs
  always_comb begin
    if (op_s != ALU_NONE) begin
      resultado = alu_y_s;
      we_s      = (instr_s.rd != 5'd0);
    end else begin
      resultado = 32'd0;
      we_s      = 1'b0;
    end
  end

  assign unused_s = ^{pc_r[1:0], pc_r[31:IM_AW+2], instr_s.shamt};

endmodule

// File: tb/tb_cpu_control_rtype.sv
// Self-checking bench for cpu_control_rtype: directed programs plus a random
// program, checked against an instruction-level reference model.
module tb_cpu_control_rtype;

  localparam int IM_DEPTH = 64;

  logic        clk_CPU = 1'b0;
  logic        rst_n   = 1'b1;
  logic [31:0] resultado;

  cpu_control_rtype #(.IM_DEPTH(IM_DEPTH), .RF_DEPTH(32)) dut (
    .clk_CPU   (clk_CPU),
    .rst_n     (rst_n),
    .resultado (resultado)
  );

  always #5 clk_CPU = ~clk_CPU;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] m_im [IM_DEPTH];
  logic [31:0] m_rf [32];
  int          m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rinst(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  // Architectural meaning of one instruction against the model register file
  function automatic logic [31:0] model_result(input logic [31:0] ins, output bit wr);
    logic [31:0] a, b, r;
    bit ok;
    int rs, rt, rd;
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    a  = (rs == 0) ? 32'd0 : m_rf[rs];
    b  = (rt == 0) ? 32'd0 : m_rf[rt];
    ok = (ins[31:26] == 6'd0);
    r  = 32'd0;
    if      (ins[5:0] == 6'h20) r = a + b;
    else if (ins[5:0] == 6'h22) r = a - b;
    else if (ins[5:0] == 6'h24) r = a & b;
    else if (ins[5:0] == 6'h25) r = a | b;
    else if (ins[5:0] == 6'h27) r = ~(a | b);
    else if (ins[5:0] == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else ok = 1'b0;
    wr = ok && (rd != 0);
    return ok ? r : 32'd0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < IM_DEPTH; i++) m_im[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) check(tag, dut.BR.registerBank[i], m_rf[i]);
  endtask

  // Reset, preload memories from the model, hold reset across one edge, release
  task automatic load_and_reset();
    logic [31:0] exp;
    bit wr;
    @(negedge clk_CPU);
    rst_n = 1'b0;
    #1;
    check("pc_async_reset", dut.pc_r, 32'd0);
    m_pc = 0;
    for (int i = 0; i < IM_DEPTH; i++) dut.IM.instBank[i] = m_im[i];
    for (int i = 0; i < 32; i++) dut.BR.registerBank[i] = m_rf[i];
    #1;
    exp = model_result(m_im[0], wr);
    check("result_in_reset", resultado, exp);
    @(posedge clk_CPU);
    #1;
    check("pc_held_in_reset", dut.pc_r, 32'd0);
    check_all_regs("no_write_in_reset");
    @(negedge clk_CPU);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    logic [31:0] ins, exp;
    bit wr;
    repeat (n) begin
      #1;
      ins = m_im[m_pc / 4];
      exp = model_result(ins, wr);
      check("resultado", resultado, exp);
      @(posedge clk_CPU);
      #1;
      if (wr) m_rf[int'(ins[15:11])] = exp;
      m_pc = (m_pc + 4) % (4 * IM_DEPTH);
      check("pc", dut.pc_r, 32'(m_pc));
      @(negedge clk_CPU);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fl [6];
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24;
    fl[3] = 6'h25; fl[4] = 6'h27; fl[5] = 6'h2A;

    // Power-up without reset: PC from its initial value, empty IM gives 0
    #1;
    check("pc_initial", dut.pc_r, 32'd0);
    check("result_initial", resultado, 32'd0);

    // add
    clear_model();
    m_rf[1] = 32'd5; m_rf[2] = 32'd3;
    m_im[0] = rinst(1, 2, 3, 6'h20);
    load_and_reset();
    check("add_result", resultado, 32'd8);
    step(1);
    check("add_r3", dut.BR.registerBank[3], 32'd8);

    // sub wraps modulo 2^32
    clear_model();
    m_rf[1] = 32'd3; m_rf[2] = 32'd5;
    m_im[0] = rinst(1, 2, 4, 6'h22);
    load_and_reset();
    check("sub_result", resultado, 32'hFFFF_FFFE);
    step(1);
    check("sub_r4", dut.BR.registerBank[4], 32'hFFFF_FFFE);

    // and / or / nor
    clear_model();
    m_rf[1] = 32'hF0F0_F0F0; m_rf[2] = 32'h0FF0_0FF0;
    m_im[0] = rinst(1, 2, 5, 6'h24);
    m_im[1] = rinst(1, 2, 6, 6'h25);
    m_im[2] = rinst(1, 2, 7, 6'h27);
    load_and_reset();
    step(3);
    check("and_r5", dut.BR.registerBank[5], 32'h00F0_00F0);
    check("or_r6",  dut.BR.registerBank[6], 32'hFFF0_FFF0);
    check("nor_r7", dut.BR.registerBank[7], 32'h000F_000F);

    // slt is signed
    clear_model();
    m_rf[1] = 32'hFFFF_FFFF; m_rf[2] = 32'd1;
    m_im[0] = rinst(1, 2, 8, 6'h2A);
    m_im[1] = rinst(2, 1, 8, 6'h2A);
    load_and_reset();
    step(1);
    check("slt_r8_true", dut.BR.registerBank[8], 32'd1);
    step(1);
    check("slt_r8_false", dut.BR.registerBank[8], 32'd0);

    // rd=0, non-R-type opcode, R0 reads 0 despite array contents, async reset
    clear_model();
    m_rf[0] = 32'hDEAD_BEEF; m_rf[1] = 32'h11; m_rf[2] = 32'h22; m_rf[10] = 32'h55;
    m_im[0] = rinst(1, 2, 0, 6'h20);
    m_im[1] = {6'h23, 5'd1, 5'd10, 16'h0004};
    m_im[2] = rinst(0, 1, 9, 6'h20);
    load_and_reset();
    step(2);
    check("nop_pc", dut.pc_r, 32'd8);
    check("r0_untouched", dut.BR.registerBank[0], 32'hDEAD_BEEF);
    check("r10_untouched", dut.BR.registerBank[10], 32'h55);
    step(1);
    check("r0_reads_zero", dut.BR.registerBank[9], 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("pc_midcycle_reset", dut.pc_r, 32'd0);
    m_pc = 0;
    @(negedge clk_CPU);
    rst_n = 1'b1;
    step(3);

    // Same-cycle write is seen only by the next instruction
    clear_model();
    m_rf[1] = 32'd7;
    m_im[0] = rinst(1, 1, 1, 6'h20);
    m_im[1] = rinst(1, 0, 2, 6'h20);
    load_and_reset();
    check("hazard_old_value", resultado, 32'd14);
    step(2);
    check("hazard_r1", dut.BR.registerBank[1], 32'd14);
    check("hazard_r2", dut.BR.registerBank[2], 32'd14);

    // Random program over the full IM, wrap, then restart from reset
    clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = $urandom;
    for (int i = 0; i < IM_DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) m_im[i] = $urandom;
      else m_im[i] = rinst($urandom_range(0, 31), $urandom_range(0, 31),
                           $urandom_range(0, 31), fl[$urandom_range(0, 5)]);
    end
    load_and_reset();
    step(IM_DEPTH);
    check("wrap_pc", dut.pc_r, 32'd0);
    step(1);
    check_all_regs("random_regs");
    step(5);
    load_and_reset();
    step(3);
    check_all_regs("restart_regs");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_rtype.md
CPU_CONTROL_RTYPE -- requirements
Module: cpu_control_rtype

Interface
REQ-001 Parameter IM_DEPTH, default 64, SHALL set the number of 32-bit instruction words; it is a power of two.
REQ-002 Parameter RF_DEPTH, default 32, SHALL set the number of 32-bit registers; it is fixed at 32 for MIPS encoding.
REQ-003 Port clk_CPU, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset; reset is asynchronous and active-low.
REQ-005 Port resultado, output, 32 bits, SHALL carry the combinational ALU result of the current instruction.

Function
REQ-006 The block SHALL be a single-cycle MIPS R-type datapath: PC, instruction memory, register bank, ALU control, ALU.
REQ-007 PC SHALL be 32 bits, byte-addressed, and advance by 4 every rising edge while rst_n=1.
REQ-008 The instruction word SHALL be IM.instBank[PC[log2(IM_DEPTH)+1:2]], read combinationally.
REQ-009 PC SHALL wrap to 0 after the last word: PC = 4*(IM_DEPTH-1) is followed by 0.
REQ-010 Decode SHALL use opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
REQ-011 Register reads of rs and rt SHALL be combinational; reading register 0 SHALL return 0 regardless of array contents.
REQ-012 With opcode 0, funct SHALL select: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed; result 1 or 0).
REQ-013 add/sub SHALL be 32-bit modulo arithmetic with no overflow trap and no flag output.
REQ-014 resultado SHALL equal the ALU result for a supported R-type instruction and 0 for any other instruction.
REQ-015 On a rising edge with a supported R-type instruction and rd!=0, BR.registerBank[rd] SHALL be written with resultado.
REQ-016 No register write SHALL occur for rd=0, an unsupported funct, or a nonzero opcode; these execute as NOPs and PC still advances.
REQ-017 When rs or rt equals the rd written in the same cycle, the read SHALL return the old value; the new value is visible in the next instruction.
REQ-018 Hierarchy SHALL expose instance IM with array instBank[0:IM_DEPTH-1] of 32 bits, and instance BR with array registerBank[0:31] of 32 bits, so benches can preload them with readmemb.

Reset
REQ-019 rst_n=0 SHALL immediately force PC to 0, independent of the clock.
REQ-020 During reset, no register-bank write SHALL occur, and resultado SHALL reflect the instruction at address 0.
REQ-021 Reset SHALL NOT clear instBank or registerBank contents; preloaded data survives reset.
REQ-022 Deasserting reset mid-program SHALL restart execution at PC 0 on the next rising edge after release.
REQ-023 With rst_n held high from time 0, PC SHALL start at 0 via its initial value.

Structure
REQ-024 Funct codes, opcode R_TYPE=0 and the ALU operation encoding SHALL live in a shared package, cpu_rtype_pkg.
REQ-025 The ALU SHALL be a sub-module named alu_rtype, with inputs a, b and op, and output y.
REQ-026 IM and BR SHALL be submodule instances carrying exactly those instance names.

Verification
REQ-027 Preload: R1=5, R2=3, IM[0]=add $3,$1,$2 -> resultado=8 in cycle 0; R3=8 after the first edge.
REQ-028 Preload: R1=3, R2=5, IM[0]=sub $4,$1,$2 -> resultado=0xFFFFFFFE; R4=0xFFFFFFFE.
REQ-029 Preload: R1=0xF0F0F0F0, R2=0x0FF00FF0; IM[0..2]=and, or, nor into $5,$6,$7 -> 0x00F000F0, 0xFFF0FFF0, 0x000F000F.
REQ-030 Preload: R1=0xFFFFFFFF (-1), R2=1, slt $8,$1,$2 -> R8=1; swapping the operands -> R8=0.
REQ-031 IM[0]=add $0,$1,$2, and IM[1] has opcode 0x23 -> R0 reads 0, no write occurs, PC advances to 8; pull rst_n low mid-cycle -> PC=0 immediately.
REQ-032 Run IM_DEPTH+1 cycles -> PC wraps to 0 and IM[0] re-executes.
